// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store controller in front of the data RAM.
// It accepts one load or store at a time and turns byte, half and word
// accesses into aligned word accesses with a byte mask. Load data is
// extracted and sign- or zero-extended, and the result or an error comes
// back through a valid/ready response channel. LATENCY idle cycles are
// inserted between acceptance and the memory access.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   req_*                  request channel (valid/ready, wen, addr, wdata, size, unsigned)
//   resp_*                 response channel (valid/ready, rdata, err)
//   mem_valid              one-cycle memory access strobe
//   mem_raddr / mem_waddr  word-aligned address
//   mem_wen, mem_wdata     write enable and lane-shifted write data
//   mem_wmask              byte-lane mask, bits 7:4 always 0
//   mem_rdata              combinational read data, valid while mem_valid=1
module lsu_mem_ctrl #(
    parameter int unsigned LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    output logic [31:0] mem_raddr,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        l_wen;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [1:0]  l_size;
    logic        l_unsigned;

    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic        mem_valid_q;
    logic [31:0] mem_addr_q;
    logic        mem_wen_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wmask_q;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        misaligned = (size == 2'd3) ||
                     (size == 2'd1 && lane[0]) ||
                     (size == 2'd2 && lane != 2'd0);
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] base;
        case (size)
            2'd0:    base = 4'h1;
            2'd1:    base = 4'h3;
            2'd2:    base = 4'hF;
            default: base = 4'h0;
        endcase
        lane_mask = base << lane;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = rdata >> {lane, 3'b000};
        case (size)
            2'd0:    load_extend = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'd1:    load_extend = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_extend = sh;
        endcase
    endfunction

    // The access fields come straight from the request when LATENCY=0
    // (IDLE goes directly to ACCESS), otherwise from the latched copy.
    logic        src_wen;
    logic [31:0] src_addr;
    logic [31:0] src_wdata;
    logic [1:0]  src_size;

    assign src_wen   = (state == IDLE) ? req_wen   : l_wen;
    assign src_addr  = (state == IDLE) ? req_addr  : l_addr;
    assign src_wdata = (state == IDLE) ? req_wdata : l_wdata;
    assign src_size  = (state == IDLE) ? req_size  : l_size;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            l_wen        <= 1'b0;
            l_addr       <= 32'd0;
            l_wdata      <= 32'd0;
            l_size       <= 2'd0;
            l_unsigned   <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wen_q    <= 1'b0;
            mem_wdata_q  <= 32'd0;
            mem_wmask_q  <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        l_wen       <= req_wen;
                        l_addr      <= req_addr;
                        l_wdata     <= req_wdata;
                        l_size      <= req_size;
                        l_unsigned  <= req_unsigned;
                        req_ready_q <= 1'b0;
                        if (misaligned(req_size, req_addr[1:0])) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end else if (LATENCY == 0) begin
                            state       <= ACCESS;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= {src_addr[31:2], 2'b00};
                            mem_wen_q   <= src_wen;
                            mem_wdata_q <= src_wdata << {src_addr[1:0], 3'b000};
                            mem_wmask_q <= lane_mask(src_size, src_addr[1:0]);
                        end else begin
                            state <= WAIT;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state       <= ACCESS;
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= {src_addr[31:2], 2'b00};
                        mem_wen_q   <= src_wen;
                        mem_wdata_q <= src_wdata << {src_addr[1:0], 3'b000};
                        mem_wmask_q <= lane_mask(src_size, src_addr[1:0]);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    state        <= RESP;
                    mem_valid_q  <= 1'b0;
                    mem_addr_q   <= 32'd0;
                    mem_wen_q    <= 1'b0;
                    mem_wdata_q  <= 32'd0;
                    mem_wmask_q  <= 4'd0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= l_wen ? 32'd0
                                          : load_extend(mem_rdata, l_addr[1:0], l_size, l_unsigned);
                end
                RESP: begin
                    if (resp_ready) begin
                        state        <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_rdata_q <= 32'd0;
                        resp_err_q   <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low for as long as resetn is held, not only after
    // the first reset edge, so the upstream stage never sees a ready or a
    // stale response during reset.
    assign req_ready  = resetn & req_ready_q;
    assign resp_valid = resetn & resp_valid_q;
    assign resp_rdata = resetn ? resp_rdata_q : 32'd0;
    assign resp_err   = resetn & resp_err_q;
    assign mem_valid  = resetn & mem_valid_q;
    assign mem_raddr  = resetn ? mem_addr_q : 32'd0;
    assign mem_waddr  = resetn ? mem_addr_q : 32'd0;
    assign mem_wen    = resetn & mem_wen_q;
    assign mem_wdata  = resetn ? mem_wdata_q : 32'd0;
    assign mem_wmask  = {4'd0, resetn ? mem_wmask_q : 4'd0};

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl. Three instances share the request fields:
// index 0 is built with LATENCY=1, index 1 with LATENCY=0, index 2 with
// LATENCY=15. Each has its own word memory behind it.
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid [3];
    logic        resp_ready [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err [3];
    logic        mem_valid [3];
    logic [31:0] mem_raddr [3];
    logic        mem_wen [3];
    logic [31:0] mem_waddr [3];
    logic [31:0] mem_wdata [3];
    logic [7:0]  mem_wmask [3];
    logic [31:0] mem_rdata [3];

    logic        pl_clr;
    logic [2:0]  pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    int n_pass  = 0;
    int n_total = 0;

    int          cap_cycles;
    int          cap_mcnt;
    logic [31:0] cap_raddr;
    logic [31:0] cap_waddr;
    logic        cap_wen;
    logic [31:0] cap_wdata;
    logic [7:0]  cap_wmask;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        logic [31:0] ram [256];

        lsu_mem_ctrl #(.LATENCY((g == 0) ? 1 : (g == 1) ? 0 : 15)) u_dut (
            .clk          (clk),
            .resetn       (resetn),
            .req_valid    (req_valid[g]),
            .req_ready    (req_ready[g]),
            .req_wen      (req_wen),
            .req_addr     (req_addr),
            .req_wdata    (req_wdata),
            .req_size     (req_size),
            .req_unsigned (req_unsigned),
            .resp_valid   (resp_valid[g]),
            .resp_ready   (resp_ready[g]),
            .resp_rdata   (resp_rdata[g]),
            .resp_err     (resp_err[g]),
            .mem_valid    (mem_valid[g]),
            .mem_raddr    (mem_raddr[g]),
            .mem_wen      (mem_wen[g]),
            .mem_waddr    (mem_waddr[g]),
            .mem_wdata    (mem_wdata[g]),
            .mem_wmask    (mem_wmask[g]),
            .mem_rdata    (mem_rdata[g])
        );

        assign mem_rdata[g] = ram[mem_raddr[g][9:2]];

        always @(posedge clk) begin
            if (pl_clr) begin
                for (int k = 0; k < 256; k++) ram[k] <= 32'd0;
            end else if (pl_en[g]) begin
                ram[pl_idx] <= pl_data;
            end else if (mem_valid[g] && mem_wen[g]) begin
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[g][b]) ram[mem_waddr[g][9:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int i, input logic [7:0] idx, input logic [31:0] data);
        pl_en[i] = 1'b1;
        pl_idx   = idx;
        pl_data  = data;
        tick();
        pl_en    = 3'b000;
    endtask

    task automatic drive_req(input int i, input logic wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        req_wen      = wen;
        req_addr     = addr;
        req_wdata    = wdata;
        req_size     = size;
        req_unsigned = uns;
        req_valid[i] = 1'b1;
    endtask

    task automatic issue(input int i, input string tag, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        drive_req(i, wen, addr, wdata, size, uns);
        check({tag, "_req_ready"}, {31'd0, req_ready[i]}, 32'd1);
        tick();
        req_valid[i] = 1'b0;
    endtask

    // Called in the cycle after the fire edge; counts cycles until
    // resp_valid and records the memory strobe contents on the way.
    task automatic await_resp(input int i);
        cap_cycles = 1;
        cap_mcnt   = 0;
        while (!resp_valid[i] && cap_cycles < 40) begin
            if (mem_valid[i]) begin
                cap_mcnt++;
                cap_raddr = mem_raddr[i];
                cap_waddr = mem_waddr[i];
                cap_wen   = mem_wen[i];
                cap_wdata = mem_wdata[i];
                cap_wmask = mem_wmask[i];
            end
            tick();
            cap_cycles++;
        end
    endtask

    task automatic finish_resp(input int i, input string tag, input int hold,
                               input logic [31:0] exp_rdata, input logic exp_err);
        check({tag, "_resp_valid"}, {31'd0, resp_valid[i]}, 32'd1);
        check({tag, "_rdata"}, resp_rdata[i], exp_rdata);
        check({tag, "_err"}, {31'd0, resp_err[i]}, {31'd0, exp_err});
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, "_hold_valid"}, {31'd0, resp_valid[i]}, 32'd1);
            check({tag, "_hold_rdata"}, resp_rdata[i], exp_rdata);
            check({tag, "_hold_err"}, {31'd0, resp_err[i]}, {31'd0, exp_err});
            check({tag, "_hold_req_ready"}, {31'd0, req_ready[i]}, 32'd0);
        end
        resp_ready[i] = 1'b1;
        tick();
        resp_ready[i] = 1'b0;
        check({tag, "_consumed"}, {31'd0, resp_valid[i]}, 32'd0);
    endtask

    task automatic do_req(input int i, input string tag, input logic wen, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_cycles, input int exp_mcnt);
        issue(i, tag, wen, addr, wdata, size, uns);
        await_resp(i);
        check({tag, "_latency"}, cap_cycles, exp_cycles);
        check({tag, "_mem_cycles"}, cap_mcnt, exp_mcnt);
        finish_resp(i, tag, 0, exp_rdata, exp_err);
    endtask

    initial begin
        resetn       = 1'b0;
        req_wen      = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid[i]  = 1'b0;
            resp_ready[i] = 1'b0;
        end
        pl_en   = 3'b000;
        pl_idx  = 8'd0;
        pl_data = 32'd0;
        pl_clr  = 1'b1;
        tick();
        pl_clr = 1'b0;

        // Outputs during reset
        check("rst_req_ready", {31'd0, req_ready[0]}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
        check("rst_mem_valid", {31'd0, mem_valid[0]}, 32'd0);
        check("rst_mem_wmask", {24'd0, mem_wmask[0]}, 32'd0);

        preload(0, 8'd4, 32'h1122_3344);   // 0x80000010
        preload(0, 8'd0, 32'h8001_7FFF);   // 0x80000000
        preload(1, 8'd1, 32'h1234_5678);   // 0x80000004
        preload(2, 8'd1, 32'h1234_5678);

        resetn = 1'b1;
        tick();
        check("idle_req_ready", {31'd0, req_ready[0]}, 32'd1);

        // Word store then word load, LATENCY=1
        do_req(0, "st_w", 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'd0, 1'b0, 3, 1);
        check("st_w_wmask", {24'd0, cap_wmask}, 32'h0000_000F);
        check("st_w_waddr", cap_waddr, 32'h8000_0004);
        check("st_w_raddr", cap_raddr, 32'h8000_0004);
        check("st_w_wen", {31'd0, cap_wen}, 32'd1);
        check("st_w_wdata", cap_wdata, 32'hDEAD_BEEF);
        do_req(0, "ld_w", 1'b0, 32'h8000_0004, 32'd0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 3, 1);
        check("ld_w_wen", {31'd0, cap_wen}, 32'd0);

        // Byte store into lane 3, then byte and word loads
        do_req(0, "st_b", 1'b1, 32'h8000_0013, 32'h0000_00A5, 2'd0, 1'b0, 32'd0, 1'b0, 3, 1);
        check("st_b_wdata", cap_wdata, 32'hA500_0000);
        check("st_b_wmask", {24'd0, cap_wmask}, 32'h0000_0008);
        check("st_b_waddr", cap_waddr, 32'h8000_0010);
        do_req(0, "ld_b_s", 1'b0, 32'h8000_0013, 32'd0, 2'd0, 1'b0, 32'hFFFF_FFA5, 1'b0, 3, 1);
        do_req(0, "ld_b_u", 1'b0, 32'h8000_0013, 32'd0, 2'd0, 1'b1, 32'h0000_00A5, 1'b0, 3, 1);
        do_req(0, "ld_w2", 1'b0, 32'h8000_0010, 32'd0, 2'd2, 1'b0, 32'hA522_3344, 1'b0, 3, 1);

        // Half loads from the upper lane, then a misaligned half
        do_req(0, "ld_h_s", 1'b0, 32'h8000_0002, 32'd0, 2'd1, 1'b0, 32'hFFFF_8001, 1'b0, 3, 1);
        do_req(0, "ld_h_u", 1'b0, 32'h8000_0002, 32'd0, 2'd1, 1'b1, 32'h0000_8001, 1'b0, 3, 1);
        do_req(0, "ld_h_mis", 1'b0, 32'h8000_0003, 32'd0, 2'd1, 1'b0, 32'd0, 1'b1, 1, 0);
        do_req(0, "ld_w_mis", 1'b0, 32'h8000_0006, 32'd0, 2'd2, 1'b0, 32'd0, 1'b1, 1, 0);
        do_req(0, "st_size3", 1'b1, 32'h8000_0000, 32'h1111_1111, 2'd3, 1'b0, 32'd0, 1'b1, 1, 0);
        check("size3_no_write", gen_dut[0].ram[0], 32'h8001_7FFF);

        // Backpressure with a pending request behind the response
        issue(0, "bp", 1'b0, 32'h8000_0004, 32'd0, 2'd2, 1'b0);
        await_resp(0);
        check("bp_latency", cap_cycles, 3);
        drive_req(0, 1'b0, 32'h8000_0010, 32'd0, 2'd2, 1'b0);
        finish_resp(0, "bp", 5, 32'hDEAD_BEEF, 1'b0);
        check("bp_ready_after", {31'd0, req_ready[0]}, 32'd1);
        tick();
        req_valid[0] = 1'b0;
        check("bp_fired", {31'd0, req_ready[0]}, 32'd0);
        await_resp(0);
        check("bp2_latency", cap_cycles, 3);
        finish_resp(0, "bp2", 0, 32'hA522_3344, 1'b0);

        // LATENCY=0 and LATENCY=15 builds
        do_req(1, "lat0", 1'b0, 32'h8000_0004, 32'd0, 2'd2, 1'b0, 32'h1234_5678, 1'b0, 2, 1);
        do_req(2, "lat15", 1'b0, 32'h8000_0004, 32'd0, 2'd2, 1'b0, 32'h1234_5678, 1'b0, 17, 1);

        // Reset during WAIT drops the store
        issue(0, "rst_wait", 1'b1, 32'h8000_0020, 32'hCAFE_F00D, 2'd2, 1'b0);
        resetn = 1'b0;
        #1;
        check("rstw_req_ready", {31'd0, req_ready[0]}, 32'd0);
        check("rstw_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
        check("rstw_mem_valid", {31'd0, mem_valid[0]}, 32'd0);
        check("rstw_mem_waddr", mem_waddr[0], 32'd0);
        tick();
        check("rstw_held_mem_wen", {31'd0, mem_wen[0]}, 32'd0);
        check("rstw_held_req_ready", {31'd0, req_ready[0]}, 32'd0);
        resetn = 1'b1;
        #1;
        check("rstw_release_ready", {31'd0, req_ready[0]}, 32'd1);
        for (int k = 0; k < 4; k++) tick();
        check("rstw_no_resp", {31'd0, resp_valid[0]}, 32'd0);
        check("rstw_no_write", gen_dut[0].ram[8], 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
